rr_lock_arb: RTL and testbench

- Parametrised N-way arbiter; successor to the fixed 9-bit MSB-priority arbiter.
- Adds a runtime mode select (fixed MSB priority or round-robin), a registered grant, and grant locking: the owner keeps the grant until it drops its request.
- Adds optional hold-timeout preemption in round-robin mode.
- Arbitrates the 9 board-square / move-source requesters in the game datapath; any N is supported.

---
 rtl/arb_pkg.sv | 10 +
 rtl/arb_pick.sv | 64 ++++++
 rtl/rr_lock_arb.sv | 178 +++++++++++++++++
 tb/tb_rr_lock_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the round-robin / locking arbiter.
//   arb_mode_t  : runtime arbitration policy selected by the mode input
//   arb_state_t : ownership state of the grant
package arb_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational pick function of the arbiter.
// Finds the first set bit of req_mask searching downward from start and
// wrapping from 0 to N-1. In fixed mode the search always starts at N-1,
// which turns the scan into plain MSB priority.
//   req_mask [N]   : candidate requests
//   start    [IDW] : first index examined (round-robin mode only)
//   mode     [1]   : 0 = fixed MSB priority, 1 = round-robin
//   pick     [N]   : one-hot winner, all-zero when nothing requested
//   pick_id  [IDW] : index of the winner, 0 when nothing requested
//   any      [1]   : at least one candidate was present
module arb_pick
  import arb_pkg::*;
#(
  parameter int N   = 9,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_mask,
  input  logic [IDW-1:0] start,
  input  logic           mode,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           any
);

  // Index width of the doubled vector.
  localparam int DW = $clog2(2 * N);

  logic [2*N-1:0] dbl_s;
  logic [IDW-1:0] start_eff_s;
  logic [DW-1:0]  pos_s;

  // Downward scan over the doubled request vector: positions start+N down to
  // start+1 visit start, start-1, ..., 0, N-1, ..., start+1 without a modulo.
  always_comb begin
    dbl_s       = {req_mask, req_mask};
    pos_s       = '0;
    any         = 1'b0;
    pick_id     = '0;
    if (mode == ARB_RR) begin
      start_eff_s = start;
    end else begin
      start_eff_s = IDW'(N - 1);
    end
    for (int k = 0; k < N; k++) begin
      pos_s = DW'(start_eff_s) + DW'(N) - DW'(k);
      if (!any && dbl_s[pos_s]) begin
        any = 1'b1;
        if (pos_s >= DW'(N)) begin
          pick_id = IDW'(pos_s - DW'(N));
        end else begin
          pick_id = IDW'(pos_s);
        end
      end else begin
        pick_id = pick_id;
      end
    end
    if (any) begin
      pick = N'(1) << pick_id;
    end else begin
      pick = '0;
    end
  end

endmodule

// File: rtl/rr_lock_arb.sv
// N-way arbiter with runtime fixed/round-robin selection, a registered grant
// that stays locked to its owner until the owner drops its request, and an
// optional hold timeout that preempts a long-running owner in round-robin mode.
//   clock     : sole clock, posedge
//   reset_L   : synchronous active-low reset
//   mode      : 0 = fixed priority (bit N-1 highest), 1 = round-robin
//   req   [N] : request vector, held high while the grant is wanted
//   gnt   [N] : registered one-hot grant or zero
//   gnt_valid : |gnt
//   gnt_id    : index of the granted requester, 0 when no grant
//   preempt   : one-cycle pulse after a timeout moved the grant
module rr_lock_arb
  import arb_pkg::*;
#(
  parameter int N        = 9,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 0,
  parameter int CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           clock,
  input  logic           reset_L,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  localparam bit          TO_EN     = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  // Index one below v, wrapping 0 to N-1.
  function automatic logic [IDW-1:0] dec_wrap(input logic [IDW-1:0] v);
    if (v == '0) begin
      return IDW'(N - 1);
    end else begin
      return v - IDW'(1);
    end
  endfunction

  arb_state_t     state_r, state_nxt_s;
  logic [N-1:0]   gnt_r, gnt_nxt_s;
  logic           valid_r;
  logic [IDW-1:0] id_r, id_nxt_s;
  logic [IDW-1:0] ptr_r, ptr_nxt_s;
  logic [CW-1:0]  hold_r, hold_nxt_s;
  logic           preempt_r, pre_nxt_s;

  logic           rr_s, owner_req_s, others_any_s, timeout_s, load_s;
  logic [N-1:0]   others_s, mask_s, pick_s;
  logic [IDW-1:0] start_s, pick_id_s;
  logic           pick_any_s;

  arb_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_mask (mask_s),
    .start    (start_s),
    .mode     (mode),
    .pick     (pick_s),
    .pick_id  (pick_id_s),
    .any      (pick_any_s)
  );

  // Picker inputs: the owner bit is masked out so a release or timeout can
  // only hand the grant to someone else; a timeout searches from owner-1.
  always_comb begin
    rr_s         = (mode == ARB_RR);
    owner_req_s  = |(req & gnt_r);
    others_s     = req & ~gnt_r;
    others_any_s = |others_s;
    if (state_r == S_OWNED) begin
      timeout_s = TO_EN && rr_s && owner_req_s && others_any_s && (hold_r == HOLD_LAST);
      mask_s    = others_s;
    end else begin
      timeout_s = 1'b0;
      mask_s    = req;
    end
    if (timeout_s) begin
      start_s = dec_wrap(id_r);
    end else begin
      start_s = ptr_r;
    end
  end

  // Ownership state register.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next ownership state: stay owned while the owner requests or a
  // back-to-back successor exists.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = S_OWNED;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_OWNED: begin
        if (owner_req_s || pick_any_s) begin
          state_nxt_s = S_OWNED;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Grant, pointer and hold-counter updates for the next edge.
  always_comb begin
    gnt_nxt_s  = gnt_r;
    id_nxt_s   = id_r;
    ptr_nxt_s  = ptr_r;
    hold_nxt_s = hold_r;
    pre_nxt_s  = 1'b0;
    case (state_r)
      S_IDLE:  load_s = pick_any_s;
      S_OWNED: load_s = timeout_s || (!owner_req_s && pick_any_s);
      default: load_s = 1'b0;
    endcase
    if (load_s) begin
      gnt_nxt_s  = pick_s;
      id_nxt_s   = pick_id_s;
      hold_nxt_s = '0;
      pre_nxt_s  = timeout_s;
      // The served requester becomes lowest priority for the next search.
      if (rr_s) begin
        ptr_nxt_s = dec_wrap(pick_id_s);
      end else begin
        ptr_nxt_s = ptr_r;
      end
    end else if (state_nxt_s == S_IDLE) begin
      gnt_nxt_s  = '0;
      id_nxt_s   = '0;
      hold_nxt_s = '0;
    end else begin
      if (hold_r == HOLD_MAX) begin
        hold_nxt_s = hold_r;
      end else begin
        hold_nxt_s = hold_r + CW'(1);
      end
    end
  end

  // Grant datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      gnt_r     <= '0;
      valid_r   <= 1'b0;
      id_r      <= '0;
      ptr_r     <= IDW'(N - 1);
      hold_r    <= '0;
      preempt_r <= 1'b0;
    end else begin
      gnt_r     <= gnt_nxt_s;
      valid_r   <= |gnt_nxt_s;
      id_r      <= id_nxt_s;
      ptr_r     <= ptr_nxt_s;
      hold_r    <= hold_nxt_s;
      preempt_r <= pre_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = valid_r;
  assign gnt_id    = id_r;
  assign preempt   = preempt_r;

endmodule

// File: tb/tb_rr_lock_arb.sv
// Bench for rr_lock_arb: two instances (no timeout, and MAX_HOLD=4) share the
// stimulus; a behavioural model per instance pushes the expected outputs of
// every edge into a queue, and a monitor on the falling edge pops and compares.
module tb_rr_lock_arb;

  localparam int N = 9;

  typedef struct {
    logic [8:0] gnt;
    logic [3:0] id;
    logic       v;
    logic       p;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       mode = 1'b0;
  logic [8:0] req = 9'h000;

  logic [8:0] gnt0, gnt4;
  logic       gv0, gv4, pre0, pre4;
  logic [3:0] id0, id4;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q4[$];

  // Model state: owner index (-1 = none), search pointer, hold count.
  int m_owner[2];
  int m_ptr[2];
  int m_hold[2];

  rr_lock_arb #(.N(N), .MAX_HOLD(0)) dut0 (
    .clock(clock), .reset_L(reset_L), .mode(mode), .req(req),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .preempt(pre0)
  );

  rr_lock_arb #(.N(N), .MAX_HOLD(4)) dut4 (
    .clock(clock), .reset_L(reset_L), .mode(mode), .req(req),
    .gnt(gnt4), .gnt_valid(gv4), .gnt_id(id4), .preempt(pre4)
  );

  always #5 clock = ~clock;

  // First requester found walking down from start (wrapping), -1 if none.
  function automatic int pick_m(input logic [8:0] m, input int start, input logic rr);
    int s;
    s = rr ? start : N - 1;
    for (int k = 0; k < N; k++) begin
      if (m[(s - k + N) % N]) return (s - k + N) % N;
    end
    return -1;
  endfunction

  task automatic new_grant(input int u, input int n, input logic md);
    m_owner[u] = n;
    m_hold[u]  = 0;
    if (md) m_ptr[u] = (n + N - 1) % N;
  endtask

  task automatic model_step(input int u, input int mh, input logic rl, input logic md,
                            input logic [8:0] rq);
    int n;
    logic pre;
    logic [8:0] oth;
    exp_t e;
    pre = 1'b0;
    if (!rl) begin
      m_owner[u] = -1; m_ptr[u] = N - 1; m_hold[u] = 0;
    end else if (m_owner[u] < 0) begin
      if (rq != 9'h000) new_grant(u, pick_m(rq, m_ptr[u], md), md);
      else m_hold[u] = 0;
    end else begin
      oth = rq;
      oth[m_owner[u]] = 1'b0;
      if (!rq[m_owner[u]]) begin
        n = pick_m(oth, m_ptr[u], md);
        if (n < 0) begin
          m_owner[u] = -1; m_hold[u] = 0;
        end else begin
          new_grant(u, n, md);
        end
      end else if (md && mh != 0 && m_hold[u] == mh - 1 && oth != 9'h000) begin
        new_grant(u, pick_m(oth, (m_owner[u] + N - 1) % N, 1'b1), md);
        pre = 1'b1;
      end else if (m_hold[u] < mh) begin
        m_hold[u]++;
      end
    end
    e.gnt = (m_owner[u] < 0) ? 9'h000 : (9'h001 << m_owner[u]);
    e.id  = (m_owner[u] < 0) ? 4'd0 : 4'(m_owner[u]);
    e.v   = (m_owner[u] >= 0);
    e.p   = pre;
    if (u == 0) q0.push_back(e);
    else q4.push_back(e);
  endtask

  // One clock: drive inputs, let the model predict the edge, settle 1 time unit.
  task automatic cyc(input logic rl, input logic md, input logic [8:0] rq);
    reset_L = rl; mode = md; req = rq;
    @(posedge clock);
    model_step(0, 0, rl, md, rq);
    model_step(1, 4, rl, md, rq);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each instance against its queued prediction.
  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if (gnt0 !== e.gnt || id0 !== e.id || gv0 !== e.v || pre0 !== e.p) begin
        n_errors++;
        $display("FAIL sb_dut0 t=%0t: gnt=%h id=%0d v=%b p=%b expected gnt=%h id=%0d v=%b p=%b",
                 $time, gnt0, id0, gv0, pre0, e.gnt, e.id, e.v, e.p);
      end
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      n_checks++;
      if (gnt4 !== e.gnt || id4 !== e.id || gv4 !== e.v || pre4 !== e.p) begin
        n_errors++;
        $display("FAIL sb_dut4 t=%0t: gnt=%h id=%0d v=%b p=%b expected gnt=%h id=%0d v=%b p=%b",
                 $time, gnt4, id4, gv4, pre4, e.gnt, e.id, e.v, e.p);
      end
    end
  end

  initial begin
    int owner;
    int ids[9];
    logic [8:0] rq;
    logic md;
    int b;

    // Reset and quiet idle.
    cyc(1'b0, 1'b0, 9'h000);
    cyc(1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 9'h000);
      chk("idle_gnt", int'(gnt0), 0);
      chk("idle_id", int'(id0), 0);
      chk("idle_valid", int'(gv0), 0);
    end

    // Fixed priority with releases.
    cyc(1'b1, 1'b0, 9'b0_0101_0010);
    chk("fix_gnt6", int'(gnt0), 'h040);
    chk("fix_id6", int'(id0), 6);
    cyc(1'b1, 1'b0, 9'b0_0001_0010);
    chk("fix_gnt4", int'(gnt0), 'h010);
    cyc(1'b1, 1'b0, 9'b0_0000_0010);
    chk("fix_gnt1", int'(gnt0), 'h002);
    cyc(1'b1, 1'b0, 9'h000);
    chk("fix_idle", int'(gnt0), 0);

    // Round-robin sweep: every owner drops req for the cycle after its grant.
    cyc(1'b1, 1'b1, 9'h1FF);
    chk("rr_first", int'(id0), 8);
    owner = 8;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 1'b1, 9'h1FF & ~(9'h001 << owner));
      owner = (owner + N - 1) % N;
      chk("rr_sweep_id", int'(id0), owner);
      chk("rr_sweep_valid", int'(gv0), 1);
    end
    cyc(1'b1, 1'b1, 9'h000);

    // Hold timeout on the MAX_HOLD=4 instance.
    ids = '{8, 8, 8, 8, 2, 2, 2, 2, 8};
    cyc(1'b0, 1'b1, 9'h000);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b1, 9'h104);
      chk("hold_id", int'(id4), ids[i]);
      chk("hold_pre", int'(pre4), (i == 4 || i == 8) ? 1 : 0);
      chk("nohold_id", int'(id0), 8);
    end
    cyc(1'b1, 1'b1, 9'h000);

    // Release coinciding with a new request; search starts below the old owner.
    cyc(1'b0, 1'b1, 9'h000);
    cyc(1'b1, 1'b1, 9'h00A);
    chk("race_id3", int'(id0), 3);
    cyc(1'b1, 1'b1, 9'h082);
    chk("race_id1", int'(id0), 1);
    cyc(1'b1, 1'b1, 9'h080);
    chk("race_id7", int'(id0), 7);
    chk("race_id7_h4", int'(id4), 7);

    // Mode change while owned does not disturb the owner.
    cyc(1'b0, 1'b1, 9'h000);
    cyc(1'b1, 1'b1, 9'h004);
    chk("msw_id2", int'(id4), 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 9'h104);
      chk("msw_keep", int'(id4), 2);
    end
    cyc(1'b1, 1'b0, 9'h100);
    chk("msw_id8", int'(id4), 8);

    // Reset while owned.
    cyc(1'b0, 1'b1, 9'h100);
    chk("rst_owned_gnt0", int'(gnt0), 0);
    chk("rst_owned_gnt4", int'(gnt4), 0);

    // Randomised traffic: mostly single-bit changes so owners hold a while.
    rq = 9'h000;
    md = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      if ($urandom_range(0, 3) == 0) begin
        rq = 9'($urandom_range(0, 511));
      end else begin
        b = int'($urandom_range(0, 8));
        rq[b] = ~rq[b];
      end
      cyc(($urandom_range(0, 63) != 0), md, rq);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && (q0.size() > 0 || q4.size() > 0); i++) begin
      @(posedge clock);
    end
    @(posedge clock);
    #1;
    chk("sb_drained", q0.size() + q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
